tcm_port_arb: RTL

Arbiter that shares one port of the 64-bit dual-port TCM RAM between the CPU data (load/store) requester and an external requester (debug/DMA loader). Each cycle it grants at most one request, with CPU priority and an anti-starvation escalation for the external side. It drives the RAM port with address, byte-write strobes and write data, then routes the RAM's one-cycle registered read data back to the winning requester with an ack. It sits between the core's data-side memory interface and the RAM port; the other RAM port stays dedicated to instruction fetch.

---
 rtl/tcm_port_arb.sv | 70 +++++++
 1 files changed

// File: rtl/tcm_port_arb.sv
// tcm_port_arb: shares one TCM RAM port between the CPU data side and an external requester
//   clk_i, rst_i            clock, async active-high reset
//   cpu_* / ext_*           request (rd, byte-write strobes, byte address, write data),
//                           accept (grant this cycle), ack + read data one cycle later
//   ext_error_o             external access outside the RAM, valid with ext_ack_o
//   ram_addr_o/_data_o/_wr_o/_data_i   RAM port (registered read-first, 1-cycle latency)
module tcm_port_arb #(
  parameter int TCM_MEM_DEPTH = 32,
  parameter int STARVE_LIMIT = 4,
  localparam int AW = $clog2(TCM_MEM_DEPTH * 1024 / 8)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_rd_i,
  input  logic [7:0]    cpu_wr_i,
  input  logic [31:0]   cpu_addr_i,
  input  logic [63:0]   cpu_data_wr_i,
  output logic          cpu_accept_o,
  output logic          cpu_ack_o,
  output logic [63:0]   cpu_data_rd_o,
  input  logic          ext_rd_i,
  input  logic [7:0]    ext_wr_i,
  input  logic [31:0]   ext_addr_i,
  input  logic [63:0]   ext_data_wr_i,
  output logic          ext_accept_o,
  output logic          ext_ack_o,
  output logic [63:0]   ext_data_rd_o,
  output logic          ext_error_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [63:0]   ram_data_o,
  output logic [7:0]    ram_wr_o,
  input  logic [63:0]   ram_data_i
);
  typedef enum logic [1:0] {IDLE, CPU, EXT} owner_t;
  owner_t owner;
  logic err;
  logic [3:0] starve_cnt;
  logic cpu_req, ext_req, cpu_grant, ext_grant, ext_oor;
  always_comb begin
    cpu_req = cpu_rd_i | (|cpu_wr_i);
    ext_req = ext_rd_i | (|ext_wr_i);
    // external wins when alone or once it has lost STARVE_LIMIT cycles in a row
    ext_grant = ext_req & (~cpu_req | (starve_cnt >= 4'(STARVE_LIMIT)));
    cpu_grant = cpu_req & ~ext_grant;
    ext_oor = |ext_addr_i[31:AW+3];
    cpu_accept_o = cpu_grant;
    ext_accept_o = ext_grant;
    ram_addr_o = cpu_grant ? cpu_addr_i[AW+2:3] : ext_grant ? ext_addr_i[AW+2:3] : '0;
    ram_data_o = cpu_grant ? cpu_data_wr_i : ext_grant ? ext_data_wr_i : '0;
    // out-of-range external writes are accepted but must not touch the RAM
    ram_wr_o = cpu_grant ? cpu_wr_i : (ext_grant & ~ext_oor) ? ext_wr_i : '0;
    cpu_ack_o = owner == CPU;
    ext_ack_o = owner == EXT;
    ext_error_o = ext_ack_o & err;
    cpu_data_rd_o = cpu_ack_o ? ram_data_i : '0;
    ext_data_rd_o = (ext_ack_o & ~err) ? ram_data_i : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner <= IDLE;
      err <= 1'b0;
      starve_cnt <= '0;
    end else begin
      owner <= cpu_grant ? CPU : ext_grant ? EXT : IDLE;
      err <= ext_grant & ext_oor;
      // a waiting ext request that was not granted necessarily lost to the CPU
      starve_cnt <= (~ext_req | ext_grant) ? '0 : starve_cnt + 4'd1;
    end
  end
endmodule
